// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin arbiter sharing one start/done memory port between
//             the instruction-fetch and load/store requesters of the core.
//             Steers address/data/size/operation to memory and returns read
//             data with a one-cycle done pulse. A watchdog ends transactions
//             that memory never completes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255   // BUSY cycles before abort; 0 disables
) (
    input  logic                  clk,
    input  logic                  reset,

    // Instruction-fetch requester
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,

    // Load/store requester
    input  logic                  d_start,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_write,
    output logic                  d_done,

    // Shared read-data return
    output logic [DATA_WIDTH-1:0] rdata,

    // Memory port
    output logic                  mem_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    output logic                  mem_write,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    // Status
    output logic                  busy,
    output logic                  bus_error
);

    // Fetches are always 32-bit instruction words.
    localparam logic [1:0] c_FETCH_SIZE = 2'b10;

    // The watchdog counter is 8 bits wide; the abort fires on the last
    // permitted BUSY cycle so that memory sees exactly TIMEOUT start cycles.
    localparam bit         c_WDOG_EN    = (TIMEOUT != 0);
    localparam logic [7:0] c_CNT_LAST   = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                  state_q,      state_d;
    logic                    owner_q,      owner_d;       // 0 = fetch, 1 = data
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              cnt_q,        cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q,      rdata_d;
    logic                    aborted_q,    aborted_d;
    logic                    bus_error_q,  bus_error_d;

    logic                    w_owner_start;
    logic                    w_in_busy;
    logic                    w_in_resp;

    // Start level of whichever requester currently owns the port.
    assign w_owner_start = owner_q ? d_start : i_start;
    assign w_in_busy     = (state_q == S_BUSY);
    assign w_in_resp     = (state_q == S_RESP);

    // State and datapath registers; reset returns to IDLE with fetch winning
    // the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            rdata_q      <= '0;
            aborted_q    <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            aborted_q    <= aborted_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Next-state logic: grant, watchdog count, read-data capture, abort flag.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        aborted_d    = aborted_q;
        bus_error_d  = bus_error_q;

        case (state_q)
            S_IDLE: begin
                // mem_done carries no meaning here and is ignored.
                if (i_start || d_start) begin
                    if (i_start && d_start) begin
                        owner_d      = ~last_grant_q;
                        last_grant_d = ~last_grant_q;
                    end else begin
                        owner_d      = d_start;
                        last_grant_d = d_start;
                    end
                    cnt_d     = 8'd0;
                    aborted_d = 1'b0;
                    state_d   = S_BUSY;
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // A requester that gives up mid-cycle still lets memory
                // finish, but is not sent a done pulse.
                if (!w_owner_start) begin
                    aborted_d = 1'b1;
                end
                if (mem_done) begin
                    // Completion beats a simultaneous watchdog expiry.
                    rdata_d = (owner_q && d_write) ? '0 : mem_rdata;
                    state_d = S_RESP;
                end else if (c_WDOG_EN && (cnt_q == c_CNT_LAST)) begin
                    rdata_d     = '0;
                    bus_error_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                aborted_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory port steering: driven only while a transaction is in flight,
    // otherwise every memory output is held at zero.
    always_comb begin
        mem_start = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = 2'b00;
        mem_write = 1'b0;
        if (w_in_busy) begin
            mem_start = 1'b1;
            if (owner_q) begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_size  = d_size;
                mem_write = d_write;
            end else begin
                mem_addr  = i_addr;
                mem_size  = c_FETCH_SIZE;
            end
        end
    end

    // Completion pulses and status; the done pulse goes only to the owner
    // and is suppressed when the owner dropped its request.
    assign i_done    = w_in_resp && !owner_q && !aborted_q;
    assign d_done    = w_in_resp &&  owner_q && !aborted_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign bus_error = bus_error_q;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (start/done handshake) between the instruction-fetch requester and the load/store data requester of the multicycle RV64 core.
- Both requesters hold their start high until they see their done. The arbiter grants round-robin, steers address, data, size and operation to memory, and returns read data with a one-cycle done pulse.
- A watchdog ends transactions that memory never completes.

Parameters:
- ADDR_WIDTH, 64, width of byte addresses.
- DATA_WIDTH, 64, width of read and write data.
- TIMEOUT, 255, number of BUSY cycles without mem_done before abort. 0 disables the watchdog. The counter is 8 bits, so the maximum is 255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_start is high.
- i_done  out  1  one-cycle fetch completion pulse.
- d_start  in  1  data request; held until d_done.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- d_write  in  1  1 = store, 0 = load.
- d_done  out  1  one-cycle data completion pulse.
- rdata  out  DATA_WIDTH  registered read data; valid while i_done or d_done is high.
- mem_start  out  1  memory request.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_size  out  2  memory access size.
- mem_write  out  1  memory operation.
- mem_done  in  1  memory completion; valid only while mem_start is high.
- mem_rdata  in  DATA_WIDTH  memory read data, sampled on mem_done.
- busy  out  1  high when the state is not IDLE.
- bus_error  out  1  sticky watchdog-abort flag.

Behaviour:
- States: IDLE, BUSY, RESP. Registers: owner (0 = fetch, 1 = data), last_grant, cnt[7:0], rdata_q, aborted, bus_error.
- Reset (async): state IDLE, owner 0, last_grant 1 (so fetch wins the first tie), cnt 0, rdata_q 0, bus_error 0. Every output is 0.
- IDLE:
  - Only i_start: owner=0. Only d_start: owner=1. Both: owner=~last_grant.
  - On any request, go to BUSY, set last_grant=owner, clear cnt.
  - mem_done is ignored in IDLE.
- BUSY:
  - mem_start=1 combinationally from the state.
  - owner=0: mem_addr=i_addr, mem_size=2'b10, mem_write=0, mem_wdata=0.
  - owner=1: mem_addr, mem_size, mem_write and mem_wdata come from the d_* inputs.
  - Outside BUSY, all mem_* outputs are 0.
  - cnt increments each BUSY cycle.
  - mem_done=1: rdata_q<=mem_rdata (0 on a store), go to RESP.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: rdata_q<=0, bus_error<=1, go to RESP.
  - mem_done and timeout in the same cycle: mem_done wins; bus_error is not set.
- Owner abort: if the owner's start falls while in BUSY, set aborted. The memory cycle still runs to completion or timeout. In RESP no done pulse is issued. aborted clears on leaving RESP.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - The owner's done=1 unless aborted; the other requester's done stays 0.
  - rdata=rdata_q throughout RESP; it holds its value afterwards until the next capture.
- Latency: a request seen in IDLE at cycle 0 gives mem_start at cycle 1. mem_done at cycle k (k≥1) gives done at cycle k+1. Minimum start-to-done is 2 cycles.
- The requester must drop start in the cycle after done. A start still high in IDLE is treated as a new request.
- Fairness: under continuous dual requests, grants strictly alternate. A single requester can be granted back-to-back; IDLE costs one cycle between transactions.
- Reset mid-transaction: immediate return to IDLE with mem_start=0 and no done pulse. A late mem_done after reset is ignored.
- bus_error clears only on reset.

Test Plan:
- Single fetch: i_start=1, i_addr=0x1000, memory replies at the 3rd BUSY cycle with mem_rdata=0x00500093 -> mem_start cycles 1–3, mem_size=10, mem_write=0, i_done=1 at cycle 4, rdata=0x00500093, busy low at cycle 5.
- Dual request from reset: i_start and d_start both raised at cycle 0 and held -> fetch granted first; data granted next; with both held continuously, grants alternate I,D,I,D for 4 transactions.
- Store: d_start, d_write=1, d_size=11, d_addr=0x2008, d_wdata=0xDEADBEEFCAFEF00D -> mem_* outputs carry exactly these values during BUSY; d_done one cycle; rdata=0.
- Watchdog: TIMEOUT=4, memory never responds -> mem_start high for 4 cycles, then the owner's done fires with rdata=0 and bus_error=1 and stays 1; a later normal transaction leaves bus_error at 1.
- Abort: d_start dropped on the 2nd BUSY cycle, mem_done on the 4th -> no d_done pulse, return to IDLE, i_start then serviced normally.
- Async reset asserted mid-BUSY (not on a clock edge) -> mem_start, busy and done outputs go to 0 immediately; after release, a tie is granted to fetch.
